sleep_cycle_controller: RTL and testbench

- Parametrised next-generation physical-state controller for the mimosa's sleep/wake behaviour.
- Extends the two-state awake/asleep scheme with:
  - multi-bit energy and stress indicators;
  - programmable sleep/wake thresholds with hysteresis;
  - a drowsy settling phase and an enforced minimum sleep length;
  - an explicit waking phase.
- Sits between the energy/stress level trackers and the mood/energy update logic, and drives their inc/dec enables.
- Evaluation advances only on a slow `tick`, so it can run at the system clock.

---
 rtl/mimosa_pkg.sv | 23 ++
 rtl/sleep_cycle_controller_if.sv | 31 +++
 rtl/sat_tick_counter.sv | 33 +++
 rtl/sleep_cycle_controller.sv | 177 +++++++++++++++++
 tb/tb_sleep_cycle_controller.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mimosa_pkg.sv
// Shared mimosa definitions: physical-state encoding, default sleep/wake thresholds
// reused by the mood controller, and a small elaboration-time helper.
package mimosa_pkg;

    typedef enum logic [1:0] {
        ST_AWAKE  = 2'd0,
        ST_DROWSY = 2'd1,
        ST_ASLEEP = 2'd2,
        ST_WAKING = 2'd3
    } state_e;

    localparam int DEF_IND_W          = 4;
    localparam int DEF_SLEEP_EN_TH    = 4;
    localparam int DEF_WAKE_EN_TH     = 12;
    localparam int DEF_STRESS_WAKE_TH = 8;
    localparam int DEF_DROWSY_TICKS   = 3;
    localparam int DEF_MIN_SLEEP      = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sleep_cycle_controller_if.sv
// Indicator inputs and enable/status outputs of the sleep cycle controller,
// grouped so the trackers (master) and the controller (slave) share one bundle.
interface sleep_cycle_controller_if #(
    parameter int IND_W = mimosa_pkg::DEF_IND_W
);
    logic             tick;
    logic [IND_W-1:0] energy_indicator;
    logic [IND_W-1:0] stress_indicator;
    logic             force_wake;
    logic [1:0]       state_o;
    logic             asleep;
    logic             fell_asleep;
    logic             woke_up;
    logic             rude_wake;
    logic             en_inc;
    logic             en_dec;
    logic             st_dec;
    logic             pl_inc;

    modport master (
        output tick, energy_indicator, stress_indicator, force_wake,
        input  state_o, asleep, fell_asleep, woke_up, rude_wake,
               en_inc, en_dec, st_dec, pl_inc
    );

    modport slave (
        input  tick, energy_indicator, stress_indicator, force_wake,
        output state_o, asleep, fell_asleep, woke_up, rude_wake,
               en_inc, en_dec, st_dec, pl_inc
    );
endinterface

// File: rtl/sat_tick_counter.sv
// Saturating up-counter advanced only when enabled; clear has priority over increment.
module sat_tick_counter #(
    parameter int W     = 3,
    parameter int LIMIT = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         at_limit
);
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] value_r;

    // Count register: clear or saturating increment on enabled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= {W{1'b0}};
        end else if (en) begin
            if (clr) begin
                value_r <= {W{1'b0}};
            end else if (inc && (value_r != LIMIT_V)) begin
                value_r <= value_r + W'(1);
            end
        end
    end

    assign value    = value_r;
    assign at_limit = (value_r == LIMIT_V);
endmodule

// File: rtl/sleep_cycle_controller.sv
// Mimosa sleep/wake state machine: AWAKE -> DROWSY -> ASLEEP -> WAKING, evaluated on tick,
// with hysteresis thresholds, minimum sleep length and registered enables/pulses.
module sleep_cycle_controller
    import mimosa_pkg::*;
#(
    parameter int IND_W          = DEF_IND_W,
    parameter int SLEEP_EN_TH    = DEF_SLEEP_EN_TH,
    parameter int WAKE_EN_TH     = DEF_WAKE_EN_TH,
    parameter int STRESS_WAKE_TH = DEF_STRESS_WAKE_TH,
    parameter int DROWSY_TICKS   = DEF_DROWSY_TICKS,
    parameter int MIN_SLEEP      = DEF_MIN_SLEEP
) (
    input logic                    clk,
    input logic                    rst_n,
    sleep_cycle_controller_if.slave bus
);
    localparam int CNT_MAX = max_int(DROWSY_TICKS, MIN_SLEEP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DROWSY_LAST = CNT_W'(DROWSY_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_SLEEP);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_SLEEP - 1);

    if (WAKE_EN_TH <= SLEEP_EN_TH) begin : g_bad_thresholds
        $fatal(1, "WAKE_EN_TH must be greater than SLEEP_EN_TH");
    end
    if ((DROWSY_TICKS < 1) || (MIN_SLEEP < 1)) begin : g_bad_durations
        $fatal(1, "DROWSY_TICKS and MIN_SLEEP must be at least 1");
    end

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_s;
    logic             cnt_at_limit_s;
    logic             cnt_clr_s;
    logic             cnt_inc_s;
    logic             fell_s;
    logic             woke_s;
    logic             rude_s;
    logic [31:0]      energy_w_s;
    logic [31:0]      stress_w_s;
    logic             tired_s;
    logic             alarm_s;
    logic             wake_ok_s;

    logic asleep_r, fell_r, woke_r, rude_r, en_inc_r, en_dec_r, st_dec_r, pl_inc_r;

    sat_tick_counter #(
        .W     (CNT_W),
        .LIMIT (CNT_MAX)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.tick),
        .clr      (cnt_clr_s),
        .inc      (cnt_inc_s),
        .value    (cnt_s),
        .at_limit (cnt_at_limit_s)
    );

    assign energy_w_s = 32'(bus.energy_indicator);
    assign stress_w_s = 32'(bus.stress_indicator);
    assign tired_s    = (energy_w_s < 32'(SLEEP_EN_TH)) && (stress_w_s < 32'(STRESS_WAKE_TH));
    assign alarm_s    = (stress_w_s >= 32'(STRESS_WAKE_TH)) || bus.force_wake;
    assign wake_ok_s  = (energy_w_s >= 32'(WAKE_EN_TH));

    // Next-state, counter control and pulse qualification for the current tick
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        fell_s      = 1'b0;
        woke_s      = 1'b0;
        rude_s      = 1'b0;
        if (bus.tick) begin
            case (state_r)
                ST_AWAKE: begin
                    if (tired_s) begin
                        state_nxt_s = ST_DROWSY;
                        cnt_clr_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_AWAKE;
                    end
                end
                ST_DROWSY: begin
                    if (!tired_s) begin
                        state_nxt_s = ST_AWAKE;
                        cnt_clr_s   = 1'b1;
                    end else if ((cnt_s == DROWSY_LAST) || cnt_at_limit_s) begin
                        state_nxt_s = ST_ASLEEP;
                        cnt_clr_s   = 1'b1;
                        fell_s      = 1'b1;
                    end else begin
                        cnt_inc_s   = 1'b1;
                    end
                end
                // cnt_s >= MIN_LAST means the post-increment count has reached MIN_SLEEP
                ST_ASLEEP: begin
                    cnt_inc_s = (cnt_s < MIN_CNT);
                    if (alarm_s) begin
                        state_nxt_s = ST_WAKING;
                        woke_s      = 1'b1;
                        rude_s      = (cnt_s < MIN_LAST);
                    end else if (wake_ok_s && (cnt_s >= MIN_LAST)) begin
                        state_nxt_s = ST_WAKING;
                        woke_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_ASLEEP;
                    end
                end
                ST_WAKING: begin
                    state_nxt_s = ST_AWAKE;
                    cnt_clr_s   = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_AWAKE;
                    cnt_clr_s   = 1'b1;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register and outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_AWAKE;
            asleep_r <= 1'b0;
            fell_r   <= 1'b0;
            woke_r   <= 1'b0;
            rude_r   <= 1'b0;
            en_inc_r <= 1'b0;
            en_dec_r <= 1'b0;
            st_dec_r <= 1'b0;
            pl_inc_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            fell_r  <= fell_s;
            woke_r  <= woke_s;
            rude_r  <= rude_s;
            case (state_nxt_s)
                ST_AWAKE: begin
                    asleep_r <= 1'b0;
                    en_inc_r <= 1'b0;
                    en_dec_r <= 1'b1;
                    st_dec_r <= 1'b0;
                    pl_inc_r <= 1'b0;
                end
                ST_ASLEEP: begin
                    asleep_r <= 1'b1;
                    en_inc_r <= 1'b1;
                    en_dec_r <= 1'b0;
                    st_dec_r <= 1'b1;
                    pl_inc_r <= 1'b1;
                end
                default: begin
                    asleep_r <= 1'b0;
                    en_inc_r <= 1'b0;
                    en_dec_r <= 1'b0;
                    st_dec_r <= 1'b0;
                    pl_inc_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state_o     = state_r;
    assign bus.asleep      = asleep_r;
    assign bus.fell_asleep = fell_r;
    assign bus.woke_up     = woke_r;
    assign bus.rude_wake   = rude_r;
    assign bus.en_inc      = en_inc_r;
    assign bus.en_dec      = en_dec_r;
    assign bus.st_dec      = st_dec_r;
    assign bus.pl_inc      = pl_inc_r;
endmodule

// File: tb/tb_sleep_cycle_controller.sv
// Scoreboard bench for sleep_cycle_controller: a tick-level reference model queues the
// expected output word per clock, a monitor compares it against the DUT one edge later.
module tb_sleep_cycle_controller;
    localparam int IND_W       = 4;
    localparam int SLEEP_TH    = 4;
    localparam int WAKE_TH     = 12;
    localparam int STRESS_TH   = 8;
    localparam int DROWSY_N    = 3;
    localparam int MIN_SLEEP_N = 5;

    localparam int AWAKE  = 0;
    localparam int DROWSY = 1;
    localparam int ASLEEP = 2;
    localparam int WAKING = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sleep_cycle_controller_if #(.IND_W(IND_W)) bus ();

    sleep_cycle_controller #(
        .IND_W          (IND_W),
        .SLEEP_EN_TH    (SLEEP_TH),
        .WAKE_EN_TH     (WAKE_TH),
        .STRESS_WAKE_TH (STRESS_TH),
        .DROWSY_TICKS   (DROWSY_N),
        .MIN_SLEEP      (MIN_SLEEP_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total  = 0;
    int n_pass   = 0;
    int n_pushed = 0;
    int n_popped = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;

    // reference model: state name plus plain tick tallies
    int m_state   = AWAKE;
    int m_drowsy  = 0;
    int m_slept   = 0;

    function automatic logic [9:0] expect_word(int st, bit fell, bit woke, bit rude);
        return {2'(st), st == ASLEEP, fell, woke, rude,
                st == ASLEEP, st == AWAKE, st == ASLEEP, st == ASLEEP};
    endfunction

    function automatic logic [9:0] dut_word();
        return {bus.state_o, bus.asleep, bus.fell_asleep, bus.woke_up, bus.rude_wake,
                bus.en_inc, bus.en_dec, bus.st_dec, bus.pl_inc};
    endfunction

    task automatic check(string name, logic [9:0] act, logic [9:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b (st,asl,fell,woke,rude,einc,edec,sdec,pinc) expected %b at %0t",
                      name, act, exp, $time);
    endtask

    task automatic check_int(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // drive one clock's inputs, advance the model, queue the expected outputs
    task automatic apply(bit t, int e, int s, bit fw);
        bit tired, alarm, fell, woke, rude;
        bus.tick             = t;
        bus.energy_indicator = IND_W'(e);
        bus.stress_indicator = IND_W'(s);
        bus.force_wake       = fw;
        fell = 1'b0; woke = 1'b0; rude = 1'b0;
        tired = (e < SLEEP_TH) && (s < STRESS_TH);
        alarm = (s >= STRESS_TH) || fw;
        if (t) begin
            if (m_state == AWAKE) begin
                if (tired) begin m_state = DROWSY; m_drowsy = 0; end
            end else if (m_state == DROWSY) begin
                if (!tired) m_state = AWAKE;
                else begin
                    m_drowsy++;
                    if (m_drowsy == DROWSY_N) begin
                        m_state = ASLEEP; m_slept = 0; fell = 1'b1;
                    end
                end
            end else if (m_state == ASLEEP) begin
                m_slept++;
                if (alarm) begin
                    m_state = WAKING; woke = 1'b1; rude = (m_slept < MIN_SLEEP_N);
                end else if (e >= WAKE_TH && m_slept >= MIN_SLEEP_N) begin
                    m_state = WAKING; woke = 1'b1;
                end
            end else begin
                m_state = AWAKE;
            end
        end
        exp_q.push_back(expect_word(m_state, fell, woke, rude));
        n_pushed++;
    endtask

    task automatic step(bit t, int e, int s, bit fw);
        @(negedge clk);
        apply(t, e, s, fw);
    endtask

    // reset asserted between edges; outputs must clear without waiting for clk
    task automatic async_reset(int e, int s);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_state = AWAKE; m_drowsy = 0; m_slept = 0;
        #1;
        check("async_reset_clear", dut_word(), 10'd0);
        repeat (2) @(negedge clk);
        check("reset_hold", dut_word(), 10'd0);
        rst_n = 1'b1;
        apply(1'b1, e, s, 1'b0);
    endtask

    // scoreboard monitor: one expected word per clock while out of reset
    always @(posedge clk) begin
        #1;
        if (rst_n && (exp_q.size() > 0)) begin
            mon_exp = exp_q.pop_front();
            n_popped++;
            check("outputs", dut_word(), mon_exp);
        end
    end

    initial begin
        bit sleepy;
        bus.tick = 1'b0;
        bus.energy_indicator = '0;
        bus.stress_indicator = '0;
        bus.force_wake = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", dut_word(), 10'd0);

        // release in the hysteresis band: AWAKE with en_dec from the first clk
        rst_n = 1'b1;
        apply(1'b1, 10, 0, 1'b0);
        repeat (20) step(1'b1, 10, 0, 1'b0);

        // fall asleep, then high energy wakes naturally on the 5th asleep tick
        repeat (4) step(1'b1, 3, 2, 1'b0);
        repeat (7) step(1'b1, 15, 0, 1'b0);

        // stress spike during DROWSY aborts the descent
        step(1'b1, 3, 2, 1'b0);
        step(1'b1, 3, 9, 1'b0);
        repeat (3) step(1'b1, 10, 0, 1'b0);

        // forced wake after 2 asleep ticks is rude; tiredness re-enters DROWSY
        repeat (4) step(1'b1, 3, 2, 1'b0);
        repeat (2) step(1'b1, 3, 2, 1'b0);
        step(1'b1, 3, 2, 1'b1);
        repeat (3) step(1'b1, 3, 2, 1'b0);
        repeat (3) step(1'b1, 10, 0, 1'b0);

        // sparse ticks: transitions only on tick clocks, then reset mid-sleep
        for (int i = 0; i < 48; i++) step(i % 4 == 0, 3, 2, 1'b0);
        @(posedge clk);
        #2;
        check("asleep_before_reset", {9'd0, bus.asleep}, 10'd1);
        async_reset(3, 2);

        // randomized phases alternating between sleepy and rested energy regimes
        sleepy = 1'b0;
        for (int i = 0; i < 2400; i++) begin
            int e, s;
            if (i % 40 == 0) sleepy = ~sleepy;
            e = sleepy ? int'($urandom_range(0, 5)) : int'($urandom_range(8, 15));
            s = ($urandom % 6 == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            step(($urandom % 3) != 0, e, s, ($urandom % 25) == 0);
        end

        repeat (2) @(negedge clk);
        check_int("scoreboard_drained", n_popped, n_pushed);
        check_int("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
